// File: rtl/zstr_if.sv
// zstr valid/acknowledge stream bundle plus the enqueue side used to load the source queue.
interface zstr_if #(
  parameter int BW = 8
);
  logic          z_vld;
  logic [BW-1:0] z_bus;
  logic          z_ack;
  // Enqueue port: one transfer accepted per cycle while enq is high.
  logic          enq;
  logic [BW-1:0] enq_bus;
  logic [31:0]   enq_dly;
  logic          enq_ovf;

  modport master (
    output z_vld, z_bus, enq_ovf,
    input  z_ack, enq, enq_bus, enq_dly
  );
  modport slave (
    input  z_vld, z_bus, enq_ovf,
    output z_ack, enq, enq_bus, enq_dly
  );
endinterface

// File: rtl/zstr_src.sv
// zstr stream source: queues (bus, delay) transfers and presents them in order,
// holding each on z_vld/z_bus until acknowledged.
module zstr_src #(
  parameter int BW  = 8,
  parameter int LN  = 4,
  parameter int LNL = $clog2(LN)
) (
  input  logic        z_clk,
  input  logic        z_rst,
  zstr_if.master      z,
  output logic [31:0] cnt
);
  logic [BW-1:0]  mem_bus_q [LN];
  logic [BW-1:0]  mem_bus_d [LN];
  logic [31:0]    mem_dly_q [LN];
  logic [31:0]    mem_dly_d [LN];
  logic [LN-1:0]  mem_vld_q, mem_vld_d;
  logic [LNL-1:0] wpt_q, wpt_d, rpt_q, rpt_d;
  logic [31:0]    dcnt_q, dcnt_d, cnt_q, cnt_d;

  logic          head_vld, vld, z_trn, wr, ovf;
  logic [31:0]   head_dly;
  logic [BW-1:0] bus;

  always_comb begin
    head_vld = mem_vld_q[rpt_q];
    head_dly = mem_dly_q[rpt_q];
    vld      = head_vld && (dcnt_q == head_dly);
    bus      = vld ? mem_bus_q[rpt_q] : '0;
    z_trn    = vld & z.z_ack;
    // Full check uses the pre-edge valid bit, so a completing head does not free its slot this cycle.
    ovf      = z.enq & mem_vld_q[wpt_q];
    wr       = z.enq & ~mem_vld_q[wpt_q];
  end

  assign z.z_vld   = vld;
  assign z.z_bus   = bus;
  assign z.enq_ovf = ovf;
  assign cnt       = cnt_q;

  always_comb begin
    mem_bus_d = mem_bus_q;
    mem_dly_d = mem_dly_q;
    mem_vld_d = mem_vld_q;
    wpt_d     = wpt_q;
    rpt_d     = rpt_q;
    cnt_d     = cnt_q;
    dcnt_d    = dcnt_q;
    if (z_trn) begin
      mem_vld_d[rpt_q] = 1'b0;
      rpt_d            = rpt_q + LNL'(1);
      cnt_d            = cnt_q + 32'd1;
    end
    if (wr) begin
      mem_vld_d[wpt_q] = 1'b1;
      mem_bus_d[wpt_q] = z.enq_bus;
      mem_dly_d[wpt_q] = z.enq_dly;
      wpt_d            = wpt_q + LNL'(1);
    end
    // Delay count restarts from 0 in the cycle following a completed transfer.
    if (!head_vld || z_trn)
      dcnt_d = '0;
    else if (dcnt_q < head_dly)
      dcnt_d = dcnt_q + 32'd1;
  end

  always_ff @(posedge z_clk or posedge z_rst) begin
    if (z_rst) begin
      for (int i = 0; i < LN; i++) begin
        mem_bus_q[i] <= '0;
        mem_dly_q[i] <= '0;
      end
      mem_vld_q <= '0;
      wpt_q     <= '0;
      rpt_q     <= '0;
      dcnt_q    <= '0;
      cnt_q     <= '0;
    end else begin
      mem_bus_q <= mem_bus_d;
      mem_dly_q <= mem_dly_d;
      mem_vld_q <= mem_vld_d;
      wpt_q     <= wpt_d;
      rpt_q     <= rpt_d;
      dcnt_q    <= dcnt_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_zstr_src.sv
// Directed bench for zstr_src: reset, streaming, delay, backpressure, overflow, wrap.
module tb_zstr_src;
  logic        z_clk = 1'b0;
  logic        z_rst;
  logic [31:0] cnt;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        rnd_on = 1'b0;
  logic [7:0]  sent_q [$];
  logic [7:0]  exp_q  [$];

  zstr_if #(.BW(8)) zif ();

  zstr_src #(.BW(8), .LN(4)) dut (
    .z_clk (z_clk),
    .z_rst (z_rst),
    .z     (zif.master),
    .cnt   (cnt)
  );

  always #5 z_clk = ~z_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic trn(input logic [7:0] b, input logic [31:0] d, output logic o);
    zif.enq     = 1'b1;
    zif.enq_bus = b;
    zif.enq_dly = d;
    #1;
    o = zif.enq_ovf;
    if (o) $display("ERROR: zstr_src overflow");
    @(posedge z_clk); #1;
    zif.enq = 1'b0;
  endtask

  task automatic step();
    @(posedge z_clk); #1;
  endtask

  // A transfer seen here completes on the following rising edge.
  always @(negedge z_clk) begin
    if (!z_rst && zif.z_vld && zif.z_ack) begin
      sent_q.push_back(zif.z_bus);
      $display("DEBUG: SENT %h", zif.z_bus);
    end
  end

  initial forever begin
    @(posedge z_clk); #1;
    if (rnd_on) zif.z_ack = 1'($urandom_range(0, 1));
  end

  initial begin
    logic        o;
    logic [31:0] c0;
    int          tries;
    z_rst = 1'b1;
    zif.z_ack = 1'b0;
    zif.enq = 1'b0;
    zif.enq_bus = '0;
    zif.enq_dly = '0;
    #1;
    chk("rst_vld", 32'(zif.z_vld), 0);
    chk("rst_bus", 32'(zif.z_bus), 0);
    chk("rst_cnt", cnt, 0);
    repeat (2) @(posedge z_clk);
    #1 z_rst = 1'b0;
    step();

    // Streaming: three dly=0 entries, ack held high
    zif.z_ack = 1'b1;
    trn(8'h11, 0, o); chk("str_vld0", 32'(zif.z_vld), 1); chk("str_bus0", 32'(zif.z_bus), 32'h11);
    trn(8'h22, 0, o); chk("str_vld1", 32'(zif.z_vld), 1); chk("str_bus1", 32'(zif.z_bus), 32'h22);
    trn(8'h33, 0, o); chk("str_vld2", 32'(zif.z_vld), 1); chk("str_bus2", 32'(zif.z_bus), 32'h33);
    step();
    chk("str_cnt", cnt, 3);
    chk("str_end", 32'(zif.z_vld), 0);
    chk("str_n", 32'(sent_q.size()), 3);
    if (sent_q.size() == 3) chk("str_ord", {8'h0, sent_q[0], sent_q[1], sent_q[2]}, 32'h00112233);

    // Delay: valid after exactly three edges, for one cycle
    trn(8'hA5, 3, o);
    chk("dly_e0", 32'(zif.z_vld), 0);
    step(); chk("dly_e1", 32'(zif.z_vld), 0);
    step(); chk("dly_e2", 32'(zif.z_vld), 0);
    step(); chk("dly_e3", 32'(zif.z_vld), 1); chk("dly_bus", 32'(zif.z_bus), 32'hA5);
    step(); chk("dly_off", 32'(zif.z_vld), 0); chk("dly_cnt", cnt, 4);

    // Backpressure: ack low for four valid cycles, high on the fifth
    zif.z_ack = 1'b0;
    c0 = cnt;
    trn(8'h5A, 0, o);
    chk("bp_vld0", 32'(zif.z_vld), 1); chk("bp_bus0", 32'(zif.z_bus), 32'h5A);
    for (int i = 1; i < 5; i++) begin
      step();
      chk($sformatf("bp_vld%0d", i), 32'(zif.z_vld), 1);
      chk($sformatf("bp_bus%0d", i), 32'(zif.z_bus), 32'h5A);
      chk($sformatf("bp_cnt%0d", i), cnt, c0);
      if (i == 4) zif.z_ack = 1'b1;
    end
    step();
    chk("bp_cnt", cnt, c0 + 1);
    chk("bp_off", 32'(zif.z_vld), 0);

    // Overflow: fifth enqueue into a full four-deep queue is dropped
    zif.z_ack = 1'b0;
    sent_q.delete();
    c0 = cnt;
    for (int i = 0; i < 5; i++) begin
      trn(8'hC1 + 8'(i), 0, o);
      chk($sformatf("ovf_%0d", i), 32'(o), (i == 4) ? 1 : 0);
    end
    zif.z_ack = 1'b1;
    repeat (6) step();
    chk("ovf_cnt", cnt, c0 + 4);
    chk("ovf_n", 32'(sent_q.size()), 4);
    for (int i = 0; i < 4 && i < sent_q.size(); i++)
      chk($sformatf("ovf_ord%0d", i), 32'(sent_q[i]), 32'hC1 + i);

    // Reset mid-simulation with three entries pending
    zif.z_ack = 1'b0;
    for (int i = 0; i < 3; i++) trn(8'h70 + 8'(i), 0, o);
    #2 z_rst = 1'b1;
    #1;
    chk("mrst_vld", 32'(zif.z_vld), 0);
    chk("mrst_bus", 32'(zif.z_bus), 0);
    chk("mrst_cnt", cnt, 0);
    sent_q.delete();
    step();
    z_rst = 1'b0;
    zif.z_ack = 1'b1;
    repeat (5) step();
    chk("mrst_none", 32'(sent_q.size()), 0);
    chk("mrst_vld2", 32'(zif.z_vld), 0);
    chk("mrst_cnt2", cnt, 0);

    // Wrap: ten transfers, random delays and random ack
    rnd_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tries = 0;
      do begin
        trn(8'h40 + 8'(i), 32'($urandom_range(0, 2)), o);
        tries++;
      end while (o && tries < 200);
      if (!o) exp_q.push_back(8'h40 + 8'(i));
    end
    for (int t = 0; t < 300 && cnt != 10; t++) step();
    rnd_on = 1'b0;
    #2 zif.z_ack = 1'b0;
    chk("wrap_cnt", cnt, 10);
    chk("wrap_n", 32'(sent_q.size()), 10);
    chk("wrap_exp", 32'(exp_q.size()), 10);
    for (int i = 0; i < 10 && i < sent_q.size() && i < exp_q.size(); i++)
      chk($sformatf("wrap_ord%0d", i), 32'(sent_q[i]), 32'(exp_q[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/zstr_src.md
# zstr_src

Testbench source for the zstr valid/acknowledge streaming interface. Transfers are queued from the bench through a task. Each transfer carries a bus value and an idle delay. The block drives them onto `z_vld`/`z_bus` in order and holds each one until the downstream drain or DUT acknowledges it. It sits directly upstream of a zstr sink and is the stimulus half of the zstr bench pair.

## Interface
Parameters:
- `BW`, 8, bus width
- `LN`, 4, queue depth (entries); must be a power of two
- `LNL`, `$clog2(LN)`, pointer width

Ports:
- `z_clk`  input  1  system clock
- `z_rst`  input  1  reset, asynchronous, active-high
- `z_vld`  output  1  transfer valid
- `z_bus`  output  BW  grouped bus signals
- `z_ack`  input  1  transfer acknowledge
- `cnt`  output  32  number of completed transfers since reset

Task:
- `trn(bus[BW-1:0], dly[31:0])`
  - enqueues one transfer;
  - `dly` is the number of idle cycles between the entry reaching the queue head and `z_vld` rising.

## Operation
- Queue storage, one set per entry: `mem_bus`, `mem_dly`, `mem_vld`.
- Pointers: write pointer `wpt` and read pointer `rpt`, each LNL bits; both wrap modulo LN.
- Head delay counter `dcnt`, 32 bits.
- `trn` behaviour:
  - If `mem_vld[wpt]` is 0: store `bus`/`dly`, set `mem_vld[wpt]`, then `wpt <= wpt+1`.
  - If `mem_vld[wpt]` is 1 (queue full): print `ERROR: zstr_src overflow`, drop the entry, leave `wpt` unchanged.
- Combinational outputs:
  - `z_vld = mem_vld[rpt] & (dcnt == mem_dly[rpt])`
  - `z_bus = z_vld ? mem_bus[rpt] : 0`
- Transfer condition: `z_trn = z_vld & z_ack`.
- Clocked behaviour, per `z_clk` edge:
  - Queue empty (`!mem_vld[rpt]`): `dcnt` holds 0.
  - Head valid and `dcnt < mem_dly[rpt]`: `dcnt` increments by 1. `z_ack` is ignored while `z_vld` is 0.
  - `z_vld` high and `z_ack` low: `dcnt`, `rpt` and `z_bus` all hold. Valid must not drop once raised.
  - `z_trn`:
    - clear `mem_vld[rpt]`;
    - `rpt <= rpt+1`;
    - `dcnt <= 0`;
    - `cnt <= cnt+1`;
    - print `DEBUG: SENT %h` with `z_bus`.
- Reset (asynchronous, any time, including mid-transfer):
  - clears all `mem_vld`;
  - zeroes `wpt`, `rpt`, `dcnt`, `cnt`;
  - pending entries are discarded.
- Reset values of outputs: `z_vld`=0, `z_bus`=0, `cnt`=0.

## Timing
- Latency from an entry becoming head to `z_vld` high:
  - `dly`=0: immediately, in the same cycle (combinational from queue state).
  - Otherwise: `dly` clock edges.
- Back-to-back traffic: with consecutive `dly`=0 entries and `z_ack` held high, `z_vld` stays high continuously and one transfer completes per cycle.
- The next entry's delay count starts on the cycle after the previous transfer completes. `dcnt` is 0 in that cycle.
- `z_ack` asserted while `z_vld` is 0 has no effect. Asserted early, it completes the transfer in the first cycle valid is high.
- Enqueue and dequeue in the same timestep:
  - Allowed on different indices.
  - On the same index (full queue with the head completing), the task sees the old `mem_vld`. The overflow is reported, and the bench must wait a cycle.
- Pointer wrap: after LN transfers, `rpt` and `wpt` return to 0 with no gap in traffic.
- Reset deasserting: the first enqueued transfer may assert `z_vld` on the first clock edge after release, subject to `dly`.

## Test plan
- **Reset values:** assert `z_rst` mid-simulation with 3 entries queued. Required: `z_vld`=0, `z_bus`=0 and `cnt`=0 immediately. No transfer occurs after release until a new `trn` call.
- **Streaming:** queue `trn(8'h11,0)`, `trn(8'h22,0)`, `trn(8'h33,0)` with `z_ack`=1. Required: `z_vld` high for 3 consecutive cycles, `z_bus` = 11, 22, 33, then `cnt`=3 and `z_vld`=0.
- **Delay:** queue `trn(8'hA5,3)` with `z_ack`=1. Required: `z_vld` rises after exactly 3 edges and is high for 1 cycle with `z_bus`=A5.
- **Backpressure:** queue `trn(8'h5A,0)` with `z_ack`=0 for 4 cycles, then 1. Required: `z_vld`=1 and `z_bus`=5A stable for 5 cycles, transfer on the 5th edge, `cnt` increments by 1.
- **Overflow:** with LN=4 and `z_ack`=0, call `trn` 5 times. Required: the 5th call reports overflow. After releasing `z_ack`, exactly 4 transfers complete, in order.
- **Wrap:** with LN=4, run 10 transfers with random `dly` in 0..2 and random `z_ack`. Required: output order matches enqueue order and `cnt`=10.
